// File: rtl/and_gate_test_sequencer.sv
// Walks every input vector of an N_IN-input gate, holds each for HOLD_CYCLES clocks,
// checks the sampled gate output against the AND of the inputs, and reports pass/done.
// Optional: define GATE_SEQ_STOP_ON_ERR_EN to end the run on the first mismatch.
module and_gate_test_sequencer #(
    parameter int N_IN        = 2,
    parameter int HOLD_CYCLES = 10,
    parameter int ERR_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_gate_out,
    output logic [N_IN-1:0]  o_gate_in,
    output logic [N_IN-1:0]  o_vec_idx,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic             o_mismatch,
    output logic [ERR_W-1:0] o_err_count
);

    localparam int               HC_W      = $clog2(HOLD_CYCLES);
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0]  VEC_LAST  = '1;
    localparam logic [ERR_W-1:0] ERR_MAX   = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            r_state;
    logic [HC_W-1:0]   r_hold_cnt;

    logic              w_sample;
    logic              w_fail;
    logic              w_end;
    logic [ERR_W-1:0]  w_err_next;

    // Sample at the last cycle of the hold window; gate_in is registered so the DUT has settled.
    assign w_sample   = (r_state == RUN) && (r_hold_cnt == HOLD_LAST);
    assign w_fail     = w_sample && (i_gate_out != (&o_gate_in));
    assign w_err_next = (o_err_count == ERR_MAX) ? o_err_count : o_err_count + 1'b1;

`ifdef GATE_SEQ_STOP_ON_ERR_EN
    assign w_end = w_fail || (o_vec_idx == VEC_LAST);
`else
    assign w_end = (o_vec_idx == VEC_LAST);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_hold_cnt  <= '0;
            o_gate_in   <= '0;
            o_vec_idx   <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_pass      <= 1'b0;
            o_mismatch  <= 1'b0;
            o_err_count <= '0;
        end else begin
            o_mismatch <= w_fail;
            case (r_state)
                IDLE, DONE: begin
                    if (i_start) begin
                        r_state     <= RUN;
                        r_hold_cnt  <= '0;
                        o_gate_in   <= '0;
                        o_vec_idx   <= '0;
                        o_busy      <= 1'b1;
                        o_done      <= 1'b0;
                        o_pass      <= 1'b0;
                        o_err_count <= '0;
                    end
                end
                RUN: begin
                    if (w_sample) begin
                        r_hold_cnt <= '0;
                        if (w_fail)
                            o_err_count <= w_err_next;
                        if (w_end) begin
                            // Vectors freeze at the last applied value so the result stays inspectable.
                            r_state <= DONE;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                            o_pass  <= !w_fail && (o_err_count == '0);
                        end else begin
                            o_vec_idx <= o_vec_idx + 1'b1;
                            o_gate_in <= o_vec_idx + 1'b1;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
